uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, the next generation of the synth's serial output path.
- Adds a small input FIFO so producers can burst words without waiting a full frame each.
- Frame format is set at elaboration: data width, parity mode and stop-bit count.
- Sits between the synth control/debug logic and the board TX pin. Frames go back-to-back whenever the FIFO holds data.

Parameters:
- CLOCK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: line rate in bit/s. BAUD_COUNT = CLOCK_FREQ/BAUD_RATE (integer division), clocks per bit; must be >= 2.
- DATA_BITS, 8: data bits per frame, legal range 5..9, sent LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  DATA_BITS  word to transmit.
- in_valid  in  1  producer offers in_data this cycle.
- in_ready  out  1  FIFO can accept; a push occurs on an edge where in_valid && in_ready.
- tx  out  1  UART line, idle high, registered.
- busy  out  1  high while a frame is on the line (start bit through last stop bit), registered.
- frame_done  out  1  one-cycle pulse in the cycle after the last stop-bit period ends, registered.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently queued, not counting the frame in flight.

Behaviour:
- Reset (rst high at an edge): tx=1, busy=0, frame_done=0, fifo_count=0, in_ready=1, state=IDLE, FIFO pointers cleared.
  - Reset mid-frame aborts the frame immediately; tx returns high on that edge and queued words are discarded.
- in_ready is combinational: in_ready = (fifo_count != FIFO_DEPTH).
- A push while full cannot occur. in_data is ignored when in_valid is low.
- FIFO push and pop on the same edge are both performed; count is unchanged.
- Pop eligibility uses the pre-edge count, so a word pushed at edge k cannot be popped at edge k.
- States: IDLE, START, DATA, PARITY, STOP. Bit timer counts 0..BAUD_COUNT-1, so every bit holds exactly BAUD_COUNT cycles.
  - IDLE: tx=1, busy=0. If fifo_count != 0: pop head into the shift register, tx<=0, busy<=1, timer<=0, go to START. Latency: word pushed at edge k into an empty FIFO while IDLE gives tx low from edge k+1.
  - START -> DATA after BAUD_COUNT cycles. DATA shifts out DATA_BITS bits LSB first, each lasting BAUD_COUNT cycles.
  - Parity is computed at pop time from the popped word. Odd mode: parity bit = ~^word. Even mode: parity bit = ^word.
  - DATA -> PARITY when PARITY != 0, else DATA -> STOP. PARITY lasts one bit period, then -> STOP.
  - STOP holds tx=1 for STOP_BITS*BAUD_COUNT cycles. At its final timer expiry, frame_done<=1 for one cycle.
    - If the FIFO is non-empty at that edge: pop, tx<=0 and go to START directly, with no idle gap and busy held high.
    - Otherwise go to IDLE with busy<=0.
- Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * BAUD_COUNT cycles.
- Width rules:
  - Timer width is $clog2(BAUD_COUNT).
  - The bit counter is wide enough for DATA_BITS.
  - FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. The count disambiguates full from empty.
- The producer may change in_data freely. Only the value at the push edge is stored.

Test Plan:
Common bench setup: CLOCK_FREQ=1000, BAUD_RATE=100, so BAUD_COUNT=10.
- 8N1: push 0xA5 while idle.
  - tx low 10 cycles starting the edge after the push.
  - Then 1,0,1,0,0,1,0,1 for 10 cycles each, then high 10 cycles.
  - frame_done pulses once at cycle 101 after the push; busy high exactly 100 cycles.
- Parity, 8 data bits:
  - PARITY=2 with 0x07 gives parity bit 1; with 0x03 gives 0.
  - PARITY=1 with 0x07 gives 0.
  - Frame length is 110 cycles.
- DATA_BITS=5, STOP_BITS=2, PARITY=0: push 0x1F -> low 10, high 50, high 20; total 80 cycles, upper in_data bits never appear.
- FIFO full/back-to-back, FIFO_DEPTH=4: push 6 words on consecutive cycles.
  - Word 0 pops immediately and words 1..4 fill the FIFO; in_ready drops and word 5 is held off.
  - Words 0..4 then transmit with no idle gap: each stop bit is followed directly by the next start bit, and busy stays high throughout.
  - in_ready returns high at the pop of word 1, and word 5 is then accepted and transmitted sixth.
- Simultaneous push/pop: push a word on the exact edge the previous frame's stop ends with 1 word queued -> fifo_count unchanged, the queued word is sent next.
- Reset mid-frame: assert rst during the DATA state with 2 words queued.
  - Same edge: tx=1, busy=0, fifo_count=0.
  - No further frames start until new pushes arrive.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a small input FIFO, frame format fixed at elaboration
module uart_tx_fifo #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int BAUD_COUNT = CLOCK_FREQ / BAUD_RATE;
  localparam int TW = $clog2(BAUD_COUNT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3, S_STOP = 3'd4;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [2:0] state;
  logic [TW-1:0] timer;
  logic [BW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shift, head;
  logic par_bit, tick, push, pop;
  assign fifo_count = count;
  assign in_ready = count != (AW+1)'(FIFO_DEPTH);
  assign head = mem[rd_ptr];
  assign push = in_valid && in_ready;
  assign tick = timer == TW'(BAUD_COUNT - 1);
  // pop uses the pre-edge count, so a word never passes through in the cycle it arrives
  assign pop = count != '0 && (state == S_IDLE ||
               (state == S_STOP && tick && bit_cnt == BW'(STOP_BITS - 1)));
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      state <= S_IDLE;
      timer <= '0;
      bit_cnt <= '0;
      shift <= '0;
      par_bit <= 1'b0;
      tx <= 1'b1;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (state != S_IDLE) timer <= tick ? '0 : timer + 1'b1;
      case (state)
        S_START:
          if (tick) begin
            tx <= shift[0];
            shift <= shift >> 1;
            bit_cnt <= '0;
            state <= S_DATA;
          end
        S_DATA:
          if (tick) begin
            if (bit_cnt == BW'(DATA_BITS - 1)) begin
              tx <= PARITY != 0 ? par_bit : 1'b1;
              state <= PARITY != 0 ? S_PARITY : S_STOP;
              bit_cnt <= '0;
            end else begin
              tx <= shift[0];
              shift <= shift >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        S_PARITY:
          if (tick) begin
            tx <= 1'b1;
            bit_cnt <= '0;
            state <= S_STOP;
          end
        S_STOP:
          if (tick) begin
            if (bit_cnt == BW'(STOP_BITS - 1)) begin
              frame_done <= 1'b1;
              busy <= 1'b0;
              state <= S_IDLE;
            end else bit_cnt <= bit_cnt + 1'b1;
          end
        default: begin
          tx <= 1'b1;
          busy <= 1'b0;
        end
      endcase
      // a pop overrides the IDLE/STOP outcome above and launches the next frame
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        shift <= head;
        par_bit <= PARITY == 1 ? ~^head : ^head;
        tx <= 1'b0;
        busy <= 1'b1;
        timer <= '0;
        state <= S_START;
      end
    end
  end
endmodule
